instruction_queue: RTL and testbench
====================================

INSTRUCTION_QUEUE -- requirements
Module: instruction_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of FIFO entries, a power of two.
REQ-002 SHALL have parameter BUSY_TIMEOUT, default 8: maximum number of cycles spent waiting for copro_ready to fall.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port wr_en, input, 1 bit: host write strobe, one entry per cycle.
REQ-006 SHALL have port wr_data, input, 32 bits: host instruction word.
REQ-007 SHALL have port full, output, 1 bit: high when count equals DEPTH.
REQ-008 SHALL have port count, output, 4 bits: number of stored entries, range 0..DEPTH.
REQ-009 SHALL have port copro_ready, input, 1 bit: coprocessor idle in its fetch state.
REQ-010 SHALL have port instruction, output, 32 bits: word presented to the coprocessor instruction input.
REQ-011 SHALL have port activate_instruction, output, 1 bit: single-cycle issue pulse.
REQ-012 SHALL have port busy, output, 1 bit: high when state is not IDLE or count is not zero.
REQ-013 SHALL have port overflow, output, 1 bit: sticky flag for a dropped write.
REQ-014 SHALL have port clr_overflow, input, 1 bit: synchronous clear of overflow.
REQ-015 SHALL have port issued, output, 16 bits: total instructions issued, wraps modulo 2^16.

Function
REQ-016 SHALL store entries in a circular buffer with head and tail pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-017 SHALL accept a write when wr_en=1 and full=0 at the edge: data goes to mem[tail], tail increments.
REQ-018 SHALL drop the write and set overflow when wr_en=1 and full=1 at the edge; a pop on the same edge does not admit the write.
REQ-019 SHALL clear overflow on clr_overflow=1; if clr_overflow and a dropped write occur on the same edge, overflow SHALL remain set.
REQ-020 SHALL update count by +1 (write only), -1 (pop only), or 0 (write and pop on the same edge); count never leaves 0..DEPTH.
REQ-021 SHALL implement FSM states IDLE, WAIT_BUSY and WAIT_DONE.
REQ-022 SHALL, in IDLE with count not zero and copro_ready=1 at an edge, on that edge: register instruction from mem[head], set activate_instruction to 1, increment head, count and issued, and go to WAIT_BUSY.
REQ-023 SHALL stay in IDLE with outputs unchanged when count=0 or copro_ready=0.
REQ-024 SHALL return activate_instruction to 0 on the edge after it is set, so it is high for exactly one cycle.
REQ-025 SHALL hold instruction stable from issue until the next issue.
REQ-026 SHALL, in WAIT_BUSY, go to WAIT_DONE when copro_ready=0.
REQ-027 SHALL, in WAIT_BUSY, go to IDLE when BUSY_TIMEOUT cycles elapse without copro_ready falling (covers instant completion); the timer is a counter cleared on entry.
REQ-028 SHALL, in WAIT_DONE, go to IDLE on the first edge with copro_ready=1.
REQ-029 SHALL have latency of 1 cycle from an accepted write into an empty IDLE queue (copro_ready=1) to activate_instruction high.
REQ-030 SHALL allow at most one instruction in flight; no issue occurs outside IDLE.
REQ-031 SHALL keep accepting writes while in WAIT_BUSY or WAIT_DONE.
REQ-032 SHALL make full, count and busy combinational from registered state.

Reset
REQ-033 SHALL, while reset=1, immediately force: state IDLE, head/tail/count 0, full 0, instruction 0x00000000, activate_instruction 0, overflow 0, issued 0, timer 0.
REQ-034 SHALL leave FIFO contents undefined after reset and never read them before they are rewritten.
REQ-035 SHALL abort an in-flight issue when reset is asserted mid-operation; after release the FSM restarts in IDLE with an empty queue.
REQ-036 SHALL ignore writes on the first edge only if reset is still asserted at that edge.

Verification
REQ-037 SHALL cover: reset, copro_ready=1, write 0x00000031 -> next cycle instruction=0x00000031, activate_instruction=1 for 1 cycle, count=0, issued=1.
REQ-038 SHALL cover: copro_ready=0, write 8 words, then a 9th -> full=1, count=8, overflow=1, 9th word never issued; clr_overflow -> overflow=0.
REQ-039 SHALL cover: 3 queued words with copro_ready dropping 1 cycle after each pulse and returning 5 cycles later -> 3 pulses in FIFO order, none while copro_ready=0, issued=3.
REQ-040 SHALL cover: copro_ready held at 1 permanently with 2 queued words -> second pulse exactly BUSY_TIMEOUT+1 cycles after the first.
REQ-041 SHALL cover: 10 writes interleaved with pops across head/tail wrap -> output order equals input order, count correct at every cycle.
REQ-042 SHALL cover: reset pulsed while in WAIT_DONE with count=4 -> all outputs return to reset values at once, and no pulse follows until a new write.

Source files
------------

// File: rtl/instruction_queue.sv
// rtl/instruction_queue.sv - host instruction FIFO that issues one word at a time to a coprocessor
module instruction_queue #(
   parameter int DEPTH        = 8,
   parameter int BUSY_TIMEOUT = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_en,
   input  logic [31:0] wr_data,
   output logic        full,
   output logic [3:0]  count,
   input  logic        copro_ready,
   output logic [31:0] instruction,
   output logic        activate_instruction,
   output logic        busy,
   output logic        overflow,
   input  logic        clr_overflow,
   output logic [15:0] issued
);

   localparam int PW = $clog2(DEPTH);
   localparam int TW = $clog2(BUSY_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [3:0]    count_q, count_d;
   logic [31:0]   instruction_q, instruction_d;
   logic          activate_q, activate_d;
   logic          overflow_q, overflow_d;
   logic [15:0]   issued_q, issued_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [31:0]   mem [DEPTH];
   logic          push;
   logic          pop;

   assign full                 = (count_q == 4'(DEPTH));
   assign count                = count_q;
   assign busy                 = (state_q != IDLE) || (count_q != 4'd0);
   assign instruction          = instruction_q;
   assign activate_instruction = activate_q;
   assign overflow             = overflow_q;
   assign issued               = issued_q;

   // A write arriving while full is dropped even if the same edge pops.
   assign push = wr_en && !full;
   assign pop  = (state_q == IDLE) && (count_q != 4'd0) && copro_ready;

   always_comb begin
      state_d       = state_q;
      head_d        = head_q;
      tail_d        = tail_q;
      count_d       = count_q;
      instruction_d = instruction_q;
      activate_d    = 1'b0;
      overflow_d    = overflow_q;
      issued_d      = issued_q;
      timer_d       = timer_q;

      if (push) begin
         tail_d = tail_q + 1'b1;
      end

      if (wr_en && full) begin
         overflow_d = 1'b1;
      end else if (clr_overflow) begin
         overflow_d = 1'b0;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + 4'd1;
         2'b01:   count_d = count_q - 4'd1;
         default: count_d = count_q;
      endcase

      case (state_q)
         IDLE: begin
            if (pop) begin
               instruction_d = mem[head_q];
               activate_d    = 1'b1;
               head_d        = head_q + 1'b1;
               issued_d      = issued_q + 16'd1;
               timer_d       = '0;
               state_d       = WAIT_BUSY;
            end
         end
         WAIT_BUSY: begin
            // Coprocessor may finish before we ever see ready fall; the timer bounds that wait.
            if (!copro_ready) begin
               state_d = WAIT_DONE;
            end else if (timer_q == TW'(BUSY_TIMEOUT - 1)) begin
               state_d = IDLE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         WAIT_DONE: begin
            if (copro_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         head_q        <= '0;
         tail_q        <= '0;
         count_q       <= 4'd0;
         instruction_q <= 32'h0000_0000;
         activate_q    <= 1'b0;
         overflow_q    <= 1'b0;
         issued_q      <= 16'd0;
         timer_q       <= '0;
      end else begin
         state_q       <= state_d;
         head_q        <= head_d;
         tail_q        <= tail_d;
         count_q       <= count_d;
         instruction_q <= instruction_d;
         activate_q    <= activate_d;
         overflow_q    <= overflow_d;
         issued_q      <= issued_d;
         timer_q       <= timer_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[tail_q] <= wr_data;
      end
   end

endmodule

// File: tb/tb_instruction_queue.sv
// tb/tb_instruction_queue.sv - directed self-checking bench for instruction_queue
module tb_instruction_queue;

   localparam int BT = 8;

   logic        clk;
   logic        reset;
   logic        wr_en;
   logic [31:0] wr_data;
   logic        full;
   logic [3:0]  count;
   logic        copro_ready;
   logic [31:0] instruction;
   logic        activate_instruction;
   logic        busy;
   logic        overflow;
   logic        clr_overflow;
   logic [15:0] issued;

   int          n_cmp;
   int          n_err;
   int          cyc;
   int          bad_pulse;
   logic        cr_at_edge;
   logic        act_prev;
   logic [31:0] got_q[$];
   int          pulse_cyc[$];

   instruction_queue #(.DEPTH(8), .BUSY_TIMEOUT(BT)) dut (
      .clk                  (clk),
      .reset                (reset),
      .wr_en                (wr_en),
      .wr_data              (wr_data),
      .full                 (full),
      .count                (count),
      .copro_ready          (copro_ready),
      .instruction          (instruction),
      .activate_instruction (activate_instruction),
      .busy                 (busy),
      .overflow             (overflow),
      .clr_overflow         (clr_overflow),
      .issued               (issued)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      cyc        = cyc + 1;
      cr_at_edge = copro_ready;
   end

   // Pulses are logged with their cycle; a pulse after an edge with ready low, or two in a row, is illegal.
   always @(negedge clk) begin
      if (!reset && activate_instruction) begin
         got_q.push_back(instruction);
         pulse_cyc.push_back(cyc);
         if (!cr_at_edge || act_prev) bad_pulse = bad_pulse + 1;
      end
      act_prev = activate_instruction;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (got !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic push_word(input logic [31:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int lim);
      int n;
      n = 0;
      while (busy && n < lim) begin
         @(negedge clk);
         n++;
      end
      check(tag, {31'd0, busy}, 32'd0);
   endtask

   task automatic wait_pulse(input string tag, input int lim);
      int n;
      n = 0;
      while (!activate_instruction && n < lim) begin
         @(negedge clk);
         n++;
      end
      check(tag, {31'd0, activate_instruction}, 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_count"}, {28'd0, count}, 32'd0);
      check({tag, "_full"}, {31'd0, full}, 32'd0);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_act"}, {31'd0, activate_instruction}, 32'd0);
      check({tag, "_instr"}, instruction, 32'h0000_0000);
      check({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
      check({tag, "_issued"}, {16'd0, issued}, 32'd0);
   endtask

   initial begin
      int model_cnt;
      int nw;
      logic w_prev;
      n_cmp = 0; n_err = 0; cyc = 0; bad_pulse = 0; act_prev = 1'b0; cr_at_edge = 1'b0;
      reset = 1'b1; wr_en = 1'b1; wr_data = 32'hDEAD_BEEF; copro_ready = 1'b1; clr_overflow = 1'b0;

      // Reset, including a write strobe that must be ignored while reset is held
      @(negedge clk);
      @(negedge clk);
      check_reset_outputs("t0");
      wr_en = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      check("t0_after_rel_count", {28'd0, count}, 32'd0);

      // Single word, ready high: one-cycle latency to the issue pulse
      got_q.delete(); pulse_cyc.delete();
      push_word(32'h0000_0031);
      check("t1_count_pre", {28'd0, count}, 32'd1);
      @(negedge clk);
      check("t1_instr", instruction, 32'h0000_0031);
      check("t1_act", {31'd0, activate_instruction}, 32'd1);
      check("t1_count", {28'd0, count}, 32'd0);
      check("t1_issued", {16'd0, issued}, 32'd1);
      @(negedge clk);
      check("t1_act_low", {31'd0, activate_instruction}, 32'd0);
      check("t1_instr_hold", instruction, 32'h0000_0031);
      wait_idle("t1_idle", 40);

      // Fill, overflow, clear priority, pop-with-dropped-write, then drain on permanent ready
      copro_ready = 1'b0;
      got_q.delete(); pulse_cyc.delete();
      for (int i = 0; i < 8; i++) begin
         wr_en = 1'b1; wr_data = 32'h100 + i;
         @(negedge clk);
      end
      wr_en = 1'b0;
      check("t2_full", {31'd0, full}, 32'd1);
      check("t2_count8", {28'd0, count}, 32'd8);
      check("t2_ovf0", {31'd0, overflow}, 32'd0);
      push_word(32'h0000_01FF);
      check("t2_ovf1", {31'd0, overflow}, 32'd1);
      check("t2_count_hold", {28'd0, count}, 32'd8);
      wr_en = 1'b1; wr_data = 32'h0000_01FE; clr_overflow = 1'b1;
      @(negedge clk);
      wr_en = 1'b0; clr_overflow = 1'b0;
      check("t2_ovf_clr_vs_drop", {31'd0, overflow}, 32'd1);
      clr_overflow = 1'b1;
      @(negedge clk);
      clr_overflow = 1'b0;
      check("t2_ovf_cleared", {31'd0, overflow}, 32'd0);
      copro_ready = 1'b1; wr_en = 1'b1; wr_data = 32'h0000_01EE;
      @(negedge clk);
      wr_en = 1'b0;
      check("t2_pop_drop_count", {28'd0, count}, 32'd7);
      check("t2_pop_drop_ovf", {31'd0, overflow}, 32'd1);
      check("t2_pop_drop_act", {31'd0, activate_instruction}, 32'd1);
      check("t2_pop_drop_instr", instruction, 32'h0000_0100);
      clr_overflow = 1'b1;
      @(negedge clk);
      clr_overflow = 1'b0;
      wait_idle("t2_idle", 200);
      check("t2_npulse", got_q.size(), 32'd8);
      for (int i = 0; i < 8 && i < got_q.size(); i++) check("t2_order", got_q[i], 32'h100 + i);
      for (int i = 1; i < 8 && i < pulse_cyc.size(); i++)
         check("t2_spacing", pulse_cyc[i] - pulse_cyc[i-1], BT + 1);
      check("t2_issued", {16'd0, issued}, 32'd9);

      // Three words with ready dropping one cycle after each pulse and returning 5 cycles later
      copro_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         wr_en = 1'b1; wr_data = 32'hA1 + i;
         @(negedge clk);
      end
      wr_en = 1'b0;
      got_q.delete(); pulse_cyc.delete();
      for (int k = 0; k < 3; k++) begin
         copro_ready = 1'b1;
         wait_pulse("t3_pulse", 30);
         copro_ready = 1'b0;
         repeat (5) @(negedge clk);
      end
      copro_ready = 1'b1;
      wait_idle("t3_idle", 40);
      check("t3_npulse", got_q.size(), 32'd3);
      for (int i = 0; i < 3 && i < got_q.size(); i++) check("t3_order", got_q[i], 32'hA1 + i);
      check("t3_bad_pulse", bad_pulse, 32'd0);
      check("t3_issued", {16'd0, issued}, 32'd12);

      // Ten writes interleaved with pops, crossing the pointer wrap; count checked every cycle
      got_q.delete(); pulse_cyc.delete();
      model_cnt = 0; nw = 0; w_prev = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         model_cnt = model_cnt + (w_prev ? 1 : 0) - (activate_instruction ? 1 : 0);
         check("t4_count", {28'd0, count}, model_cnt);
         copro_ready = !activate_instruction;
         if (nw < 10 && (i % 3) != 2) begin
            wr_en = 1'b1; wr_data = 32'hC0 + nw; nw++; w_prev = 1'b1;
         end else begin
            wr_en = 1'b0; w_prev = 1'b0;
         end
      end
      copro_ready = 1'b1;
      wait_idle("t4_idle", 40);
      check("t4_npulse", got_q.size(), 32'd10);
      for (int i = 0; i < 10 && i < got_q.size(); i++) check("t4_order", got_q[i], 32'hC0 + i);
      check("t4_issued", {16'd0, issued}, 32'd22);

      // Reset asserted mid-cycle while waiting for completion with four words queued
      copro_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         wr_en = 1'b1; wr_data = 32'hD0 + i;
         @(negedge clk);
      end
      wr_en = 1'b0;
      copro_ready = 1'b1;
      wait_pulse("t5_pulse", 10);
      copro_ready = 1'b0;
      @(negedge clk);
      check("t5_count4", {28'd0, count}, 32'd4);
      check("t5_busy", {31'd0, busy}, 32'd1);
      #2 reset = 1'b1;
      #1 check_reset_outputs("t5_async");
      @(negedge clk);
      reset = 1'b0;
      copro_ready = 1'b1;
      got_q.delete(); pulse_cyc.delete();
      repeat (20) @(negedge clk);
      check("t5_no_pulse", got_q.size(), 32'd0);
      check("t5_idle", {31'd0, busy}, 32'd0);
      push_word(32'h0000_00E5);
      @(negedge clk);
      check("t5_new_act", {31'd0, activate_instruction}, 32'd1);
      check("t5_new_instr", instruction, 32'h0000_00E5);
      check("t5_new_issued", {16'd0, issued}, 32'd1);
      wait_idle("t5_final_idle", 40);
      check("final_bad_pulse", bad_pulse, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
